// File: rtl/cla_sub_pipe_if.sv
// Operand/result valid-ready bundle for cla_sub_pipe.
// The producer and consumer both sit on the master side; the subtractor takes the slave side.
interface cla_sub_pipe_if #(
  parameter int Width = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] A;
  logic [Width-1:0] B;
  logic             BI;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] D;
  logic             BO;
  logic             OV;

  modport master (
    output in_valid, A, B, BI, out_ready,
    input  in_ready, out_valid, D, BO, OV
  );

  modport slave (
    input  in_valid, A, B, BI, out_ready,
    output in_ready, out_valid, D, BO, OV
  );
endinterface

// File: rtl/cla_sub_pipe.sv
// Pipelined D = A - B - BI with borrow-out/overflow, one CLA slice per stage; latency Stages cycles, 1 result/cycle.
// A held output (out_valid && !out_ready) freezes every stage and drops in_ready; bubbles are not compressed.
module cla_sub_pipe #(
  parameter int Width  = 64,
  parameter int Stages = 4
) (
  input logic           clk,
  input logic           reset,
  cla_sub_pipe_if.slave bus
);
  localparam int SW = Width / Stages;
  localparam int NG = SW / 4;

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // 4-bit lookahead group: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Stage k consumes operand slice k and forwards the still-unused upper slices alongside the result.
  for (genvar k = 0; k < Stages; k++) begin : g_st
    logic [Width-k*SW-1:0] a_rem;
    logic [Width-k*SW-1:0] b_rem;
    logic [SW-1:0]         a_sl;
    logic [SW-1:0]         b_sl;
    logic [SW-1:0]         sum;
    logic [NG:0]           gc;
    logic                  cin;
    logic                  v_d;
    logic                  v_q;
    logic [(k+1)*SW-1:0]   d_d;
    logic [(k+1)*SW-1:0]   d_q;

    assign a_sl = a_rem[SW-1:0];
    assign b_sl = b_rem[SW-1:0];

    if (k == 0) begin : g_in
      always_comb begin
        a_rem = bus.A;
        b_rem = bus.B;
        cin   = ~bus.BI;
        v_d   = bus.in_valid;
        d_d   = sum;
      end
    end else begin : g_in
      always_comb begin
        a_rem = g_st[k-1].g_mid.a_q;
        b_rem = g_st[k-1].g_mid.b_q;
        cin   = g_st[k-1].g_mid.c_q;
        v_d   = g_st[k-1].v_q;
        d_d   = {sum, g_st[k-1].d_q};
      end
    end

    always_comb begin
      logic [4:0] r;
      gc    = '0;
      sum   = '0;
      r     = '0;
      gc[0] = cin;
      for (int i = 0; i < NG; i++) begin
        r              = cla4(a_sl[4*i +: 4], ~b_sl[4*i +: 4], gc[i]);
        sum[4*i +: 4]  = r[3:0];
        gc[i+1]        = r[4];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (adv) begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end

    if (k < Stages - 1) begin : g_mid
      logic [Width-(k+1)*SW-1:0] a_d, a_q, b_d, b_q;
      logic                      c_d, c_q;

      always_comb begin
        a_d = a_rem[Width-k*SW-1:SW];
        b_d = b_rem[Width-k*SW-1:SW];
        c_d = gc[NG];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
          c_q <= c_d;
        end
      end
    end else begin : g_last
      logic bo_d, bo_q, ov_d, ov_q;

      always_comb begin
        bo_d = ~gc[NG];
        ov_d = (a_sl[SW-1] != b_sl[SW-1]) && (sum[SW-1] != a_sl[SW-1]);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bo_q <= 1'b0;
          ov_q <= 1'b0;
        end else if (adv) begin
          bo_q <= bo_d;
          ov_q <= ov_d;
        end
      end

      assign bus.out_valid = v_q;
      assign bus.D         = d_q;
      assign bus.BO        = bo_q;
      assign bus.OV        = ov_q;
    end
  end
endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed bench for cla_sub_pipe: vector table, backpressure stream, mid-flight reset.
module tb_cla_sub_pipe;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cla_sub_pipe_if #(.Width(W)) bus ();
  cla_sub_pipe #(.Width(W), .Stages(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vt [9];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one operand with out_ready=1 and wait (bounded) for its result.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output logic [W-1:0] d, output logic bo, output logic ov, output int lat);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.BI        = bi;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (bus.out_valid || lat >= 20) break;
      @(posedge clk); #1;
      lat++;
    end
    d  = bus.D;
    bo = bus.BO;
    ov = bus.OV;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, miscompares so far %0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] d;
    logic         bo, ov;
    int           lat;
    int           sent, got, extra;
    logic [W-1:0] stall_d;

    vt[0] = '{a: 64'd5, b: 64'd3, bi: 1'b0, d: 64'd2, bo: 1'b0, ov: 1'b0};
    vt[1] = '{a: 64'd5, b: 64'd3, bi: 1'b1, d: 64'd1, bo: 1'b0, ov: 1'b0};
    vt[2] = '{a: 64'd0, b: 64'd1, bi: 1'b0, d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b1, ov: 1'b0};
    vt[3] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, bi: 1'b0, d: 64'h7FFF_FFFF_FFFF_FFFF, bo: 1'b0, ov: 1'b1};
    vt[4] = '{a: 64'h0001_0000_0000_0000, b: 64'd1, bi: 1'b0, d: 64'h0000_FFFF_FFFF_FFFF, bo: 1'b0, ov: 1'b0};
    vt[5] = '{a: 64'h0000_0000_0001_0000, b: 64'd1, bi: 1'b0, d: 64'h0000_0000_0000_FFFF, bo: 1'b0, ov: 1'b0};
    vt[6] = '{a: 64'd0, b: 64'd0, bi: 1'b1, d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b1, ov: 1'b0};
    vt[7] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, bi: 1'b0,
              d: 64'h8000_0000_0000_0000, bo: 1'b1, ov: 1'b1};
    vt[8] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, bi: 1'b1,
              d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b1, ov: 1'b0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.BI        = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_d", bus.D, 0);
    chk("rst_bo", bus.BO, 0);
    chk("rst_ov", bus.OV, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", bus.out_valid, 0);

    // Single-operand vectors: latency and results
    for (int i = 0; i < 9; i++) begin
      run_one(vt[i].a, vt[i].b, vt[i].bi, d, bo, ov, lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_d", i), d, vt[i].d);
      chk($sformatf("v%0d_bo", i), bo, vt[i].bo);
      chk($sformatf("v%0d_ov", i), ov, vt[i].ov);
    end

    // Back-to-back stream with a 5-cycle output stall
    sent = 0;
    got  = 0;
    stall_d = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      bus.out_ready = !(cyc >= 7 && cyc < 12);
      bus.in_valid  = (sent < 8);
      bus.A         = 64'(sent + 10);
      bus.B         = 64'(sent);
      bus.BI        = 1'b0;
      @(negedge clk);
      if (cyc == 7) chk("no_bubble_before_stall", 64'(got), 3);
      if (!bus.out_ready) begin
        chk($sformatf("stall_in_ready_c%0d", cyc), bus.in_ready, 0);
        chk($sformatf("stall_out_valid_c%0d", cyc), bus.out_valid, 1);
        if (cyc == 7) stall_d = bus.D;
        else chk($sformatf("stall_hold_d_c%0d", cyc), bus.D, stall_d);
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("stream_d_%0d", got), bus.D, 64'd10);
        chk($sformatf("stream_bo_%0d", got), bus.BO, 0);
        got++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", 64'(got), 8);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk("stream_no_extra", 64'(extra), 0);

    // Reset while three operands are in flight
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = 64'(100 + i);
      bus.B        = 64'(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_d", bus.D, 0);
    #9;
    chk("midrst_held_out_valid", bus.out_valid, 0);
    reset = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk("midrst_no_ghost", 64'(extra), 0);
    run_one(64'd50, 64'd8, 1'b0, d, bo, ov, lat);
    chk("after_rst_latency", lat, 4);
    chk("after_rst_d", d, 64'd42);
    chk("after_rst_bo", bo, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
